and2_pattern_driver: RTL and testbench

AND2_PATTERN_DRIVER -- requirements
Module: and2_pattern_driver

---
 rtl/and2_pattern_driver.sv | 152 +++++++++++++++
 tb/tb_and2_pattern_driver.sv | 131 +++++++++++++
 2 files changed

// File: rtl/and2_pattern_driver.sv
// rtl/and2_pattern_driver.sv - exhaustive pattern driver and checker for a 2-input AND gate
module and2_pattern_driver #(
    parameter int unsigned SETTLE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       l_i,
    output logic       sw0_o,
    output logic       sw1_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] errcnt_o,
    output logic [3:0] failmask_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
    localparam logic [2:0] ERR_MAX  = 3'd4;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       sw0_q, sw0_d;
    logic       sw1_q, sw1_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] errcnt_q, errcnt_d;
    logic [3:0] failmask_q, failmask_d;
    logic       l_meta_q, l_sync_q;
    logic       mismatch;
    logic [1:0] idx_next;

    // Two-flop synchronizer for the CUT output; L is asynchronous to clk_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            l_meta_q <= 1'b0;
            l_sync_q <= 1'b0;
        end else begin
            l_meta_q <= l_i;
            l_sync_q <= l_meta_q;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 4'd0;
            sw0_q      <= 1'b0;
            sw1_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            errcnt_q   <= 3'd0;
            failmask_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sw0_q      <= sw0_d;
            sw1_q      <= sw1_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            errcnt_q   <= errcnt_d;
            failmask_q <= failmask_d;
        end
    end

    // The synchronized L only ever feeds result bits, never a state transition
    assign mismatch = (l_sync_q != (sw0_q & sw1_q));
    assign idx_next = idx_q + 2'd1;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sw0_d      = sw0_q;
        sw1_d      = sw1_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        errcnt_d   = errcnt_q;
        failmask_d = failmask_q;

        case (state_q)
            IDLE, FINISH: begin
                if (start_i) begin
                    state_d    = DRIVE;
                    idx_d      = 2'd0;
                    cnt_d      = 4'd0;
                    sw0_d      = 1'b0;
                    sw1_d      = 1'b0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    errcnt_d   = 3'd0;
                    failmask_d = 4'd0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    failmask_d[idx_q] = 1'b1;
                    if (errcnt_q != ERR_MAX) begin
                        errcnt_d = errcnt_q + 3'd1;
                    end
                end
                if (idx_q != 2'd3) begin
                    state_d = DRIVE;
                    idx_d   = idx_next;
                    cnt_d   = 4'd0;
                    sw0_d   = idx_next[0];
                    sw1_d   = idx_next[1];
                end else begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (errcnt_d == 3'd0);
                    sw0_d   = 1'b0;
                    sw1_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sw0_o      = sw0_q;
    assign sw1_o      = sw1_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_o     = pass_q;
    assign errcnt_o   = errcnt_q;
    assign failmask_o = failmask_q;

endmodule

// File: tb/tb_and2_pattern_driver.sv
// tb/tb_and2_pattern_driver.sv - randomized self-checking bench for and2_pattern_driver
module tb_and2_pattern_driver;

    localparam int S   = 4;
    localparam int PAT = S + 1;
    localparam int RUN = 4 * PAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       l;
    logic       sw0, sw1, busy, done, pass;
    logic [2:0] errcnt;
    logic [3:0] failmask;

    // CUT truth table indexed by {pin1,pin0}; swap models crossed wiring
    logic [3:0] tt = 4'b1000;
    logic       swap = 1'b0;

    int errors = 0;
    int checks = 0;

    and2_pattern_driver #(.SETTLE(S)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .l_i        (l),
        .sw0_o      (sw0),
        .sw1_o      (sw1),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .errcnt_o   (errcnt),
        .failmask_o (failmask)
    );

    assign l = swap ? tt[{sw0, sw1}] : tt[{sw1, sw0}];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Which patterns a given CUT gets wrong relative to a true AND
    function automatic logic [3:0] ref_mask(input logic [3:0] t, input logic sw);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            logic a, b, y;
            a = i[0];
            b = i[1];
            y = sw ? t[{a, b}] : t[{b, a}];
            m[i] = (y != (a & b));
        end
        return m;
    endfunction

    task automatic run(input logic [3:0] t, input logic sw, input int repulse);
        logic [3:0] m;
        int         ec;
        tt   = t;
        swap = sw;
        m    = ref_mask(t, sw);
        ec   = $countones(m);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int n = 1; n <= RUN; n++) begin
            check("sw_order", {30'd0, sw1, sw0}, 32'((n - 1) / PAT));
            check("busy_done_run", {30'd0, busy, done}, 32'b10);
            if (n == 1) check("cleared", {24'd0, pass, errcnt, failmask}, 32'd0);
            start = (n == repulse);
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_done_fin", {30'd0, busy, done}, 32'b01);
        check("sw_fin", {30'd0, sw1, sw0}, 32'd0);
        check("failmask", {28'd0, failmask}, {28'd0, m});
        check("errcnt", {29'd0, errcnt}, 32'(ec));
        check("pass", {31'd0, pass}, {31'd0, (ec == 0)});
        @(negedge clk);
        check("hold", {24'd0, busy, done, errcnt, failmask}, {24'd0, 2'b01, 3'(ec), m});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", {21'd0, sw1, sw0, busy, done, pass, errcnt, failmask}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", {21'd0, sw1, sw0, busy, done, pass, errcnt, failmask}, 32'd0);

        run(4'b1000, 1'b0, 0);   // correct AND
        run(4'b0000, 1'b0, 0);   // stuck at 0
        run(4'b1110, 1'b0, 0);   // OR
        run(4'b0111, 1'b0, 0);   // NAND, saturating count
        run(4'b1000, 1'b0, 7);   // restart request mid-run ignored
        run(4'b0111, 1'b0, 0);   // NAND run after a finished run
        run(4'b1000, 1'b1, 0);   // swapped wiring, AND

        // Abort during pattern 2
        tt = 4'b1000;
        swap = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2 * PAT + 1) @(negedge clk);
        check("pre_abort_sw", {30'd0, sw1, sw0}, 32'd2);
        #2 rst = 1'b1;
        #1 check("abort_zero", {21'd0, sw1, sw0, busy, done, pass, errcnt, failmask}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_idle", {21'd0, sw1, sw0, busy, done, pass, errcnt, failmask}, 32'd0);
        run(4'b1000, 1'b0, 0);

        for (int r = 0; r < 10; r++) begin
            logic [3:0] t;
            logic       sw;
            int         rp;
            t  = 4'($urandom);
            sw = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, RUN - 1)) : 0;
            run(t, sw, rp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
